rail_drive_sequencer: RTL and testbench

Sequencer for a shared contention-prone output rail node. The node has two parallel PMOS pull-ups (gates A, B, active-low) and one NMOS pull-down (gate C, active-high). The block arbitrates between two pull-up requesters and one pull-down requester. It guarantees break-before-make: a pull-up and the pull-down are never on together. Every release is followed by an enforced all-off dead time. It sits in the digital control layer directly above the rail cell and drives the cell's gate inputs.

---
 rtl/rail_drive_sequencer.sv | 138 +++++++++++++
 tb/tb_rail_drive_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rail_drive_sequencer.sv
// Break-before-make sequencer for a shared rail: two PMOS pull-ups (A/B, active-low)
// and one NMOS pull-down (C), with minimum on-time and an enforced all-off dead time.
module rail_drive_sequencer #(
  parameter int DEAD_CYC = 2,
  parameter int MIN_ON   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req_up,
  input  logic       req_dn,
  output logic [1:0] gnt_up,
  output logic       gnt_dn,
  output logic       a_n,
  output logic       b_n,
  output logic       c,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PU   = 2'd1;
  localparam logic [1:0] ST_PD   = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam logic DIR_DN = 1'b0;
  localparam logic DIR_UP = 1'b1;

  localparam logic [7:0] MIN_ON_C   = 8'(MIN_ON);
  localparam logic [3:0] DEAD_CYC_C = 4'(DEAD_CYC);

  logic [1:0] state_q, state_d;
  logic [1:0] gnt_up_q, gnt_up_d;
  logic       gnt_dn_q, gnt_dn_d;
  logic [7:0] on_cnt_q, on_cnt_d;
  logic [3:0] dead_cnt_q, dead_cnt_d;
  logic       last_dir_q, last_dir_d;
  logic       a_n_q, b_n_q, c_q, busy_q;

  logic       on_sat;
  logic [7:0] on_inc;

  assign on_sat = (on_cnt_q >= MIN_ON_C);
  assign on_inc = on_sat ? on_cnt_q : on_cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    gnt_up_d   = gnt_up_q;
    gnt_dn_d   = gnt_dn_q;
    on_cnt_d   = on_cnt_q;
    dead_cnt_d = dead_cnt_q;
    last_dir_d = last_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (en && ((|req_up) || req_dn)) begin
          // On a simultaneous request, alternate against the last direction driven.
          if ((|req_up) && (!req_dn || last_dir_q == DIR_DN)) begin
            state_d    = ST_PU;
            gnt_up_d   = req_up;
            last_dir_d = DIR_UP;
          end else begin
            state_d    = ST_PD;
            gnt_dn_d   = 1'b1;
            last_dir_d = DIR_DN;
          end
          on_cnt_d = 8'd1;
        end
      end
      ST_PU: begin
        if (!en || (on_sat && (req_up == 2'b00 || req_dn))) begin
          state_d    = ST_DEAD;
          gnt_up_d   = 2'b00;
          on_cnt_d   = 8'd0;
          dead_cnt_d = 4'd1;
        end else begin
          on_cnt_d = on_inc;
          // An empty request before MIN_ON keeps the previous grant so a PMOS stays on.
          if (req_up != 2'b00) gnt_up_d = req_up;
        end
      end
      ST_PD: begin
        if (!en || (on_sat && (!req_dn || (|req_up)))) begin
          state_d    = ST_DEAD;
          gnt_dn_d   = 1'b0;
          on_cnt_d   = 8'd0;
          dead_cnt_d = 4'd1;
        end else begin
          on_cnt_d = on_inc;
        end
      end
      default: begin
        gnt_up_d = 2'b00;
        gnt_dn_d = 1'b0;
        if (dead_cnt_q >= DEAD_CYC_C) begin
          state_d    = ST_IDLE;
          dead_cnt_d = 4'd0;
        end else begin
          dead_cnt_d = dead_cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_up_q   <= 2'b00;
      gnt_dn_q   <= 1'b0;
      on_cnt_q   <= 8'd0;
      dead_cnt_q <= 4'd0;
      last_dir_q <= DIR_DN;
      a_n_q      <= 1'b1;
      b_n_q      <= 1'b1;
      c_q        <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_up_q   <= gnt_up_d;
      gnt_dn_q   <= gnt_dn_d;
      on_cnt_q   <= on_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      last_dir_q <= last_dir_d;
      a_n_q      <= ~gnt_up_d[0];
      b_n_q      <= ~gnt_up_d[1];
      c_q        <= gnt_dn_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign gnt_up    = gnt_up_q;
  assign gnt_dn    = gnt_dn_q;
  assign a_n       = a_n_q;
  assign b_n       = b_n_q;
  assign c         = c_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rail_drive_sequencer.sv
// Directed timeline checks of the rail sequencer followed by a random soak that
// checks break-before-make and the minimum all-off gap between directions.
module tb_rail_drive_sequencer;

  localparam int DEAD_CYC = 2;
  localparam int MIN_ON   = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PU   = 2'd1;
  localparam logic [1:0] S_PD   = 2'd2;
  localparam logic [1:0] S_DEAD = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] req_up = 2'b00;
  logic       req_dn = 1'b0;
  logic [1:0] gnt_up;
  logic       gnt_dn;
  logic       a_n, b_n, c, busy;
  logic [1:0] dbg_state;

  logic [8:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  rail_drive_sequencer #(.DEAD_CYC(DEAD_CYC), .MIN_ON(MIN_ON)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_up(req_up), .req_dn(req_dn),
    .gnt_up(gnt_up), .gnt_dn(gnt_dn), .a_n(a_n), .b_n(b_n), .c(c),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Expected word: {state, busy, gnt_up, gnt_dn, a_n, b_n, c}
  function automatic logic [8:0] mk(input logic [1:0] st, input logic [1:0] gu, input logic gd);
    return {st, (st != S_IDLE), gu, gd, ~gu[0], ~gu[1], gd};
  endfunction

  task automatic step(input logic e, input logic [1:0] ru, input logic rd,
                      input logic [1:0] st, input logic [1:0] gu, input logic gd,
                      input string tag);
    logic [8:0] obs, exp;
    en = e;
    req_up = ru;
    req_dn = rd;
    exp_q.push_back(mk(st, gu, gd));
    @(posedge clk);
    #1;
    obs = {dbg_state, busy, gnt_up, gnt_dn, a_n, b_n, c};
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s empty_queue obs=%b", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s obs={st,busy,gu,gd,an,bn,c}=%b exp=%b", tag, obs, exp);
      end
    end
  endtask

  initial begin
    int prev_dir;
    int off_run;
    logic up_on, dn_on;

    // Reset
    rst_n = 1'b0;
    step(0, 2'b00, 0, S_IDLE, 2'b00, 0, "reset");
    rst_n = 1'b1;

    // 1: single pull-up held 10 cycles
    for (int i = 0; i < 10; i++) step(1, 2'b01, 0, S_PU, 2'b01, 0, "t1_hold");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t1_dead1");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t1_dead2");
    step(1, 2'b00, 0, S_IDLE, 2'b00, 0, "t1_idle");

    // 2: one-cycle request still holds MIN_ON cycles
    step(1, 2'b01, 0, S_PU, 2'b01, 0, "t2_on1");
    for (int i = 0; i < MIN_ON - 1; i++) step(1, 2'b00, 0, S_PU, 2'b01, 0, "t2_minon");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t2_dead1");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t2_dead2");
    step(1, 2'b00, 0, S_IDLE, 2'b00, 0, "t2_idle");

    // 3: contention after reset -> up first, then preempted by down
    rst_n = 1'b0;
    step(1, 2'b00, 0, S_IDLE, 2'b00, 0, "t3_reset");
    rst_n = 1'b1;
    for (int i = 0; i < MIN_ON; i++) step(1, 2'b11, 1, S_PU, 2'b11, 0, "t3_pu");
    step(1, 2'b11, 1, S_DEAD, 2'b00, 0, "t3_dead1");
    step(1, 2'b11, 1, S_DEAD, 2'b00, 0, "t3_dead2");
    step(1, 2'b11, 1, S_IDLE, 2'b00, 0, "t3_idle");
    step(1, 2'b11, 1, S_PD, 2'b00, 1, "t3_pd");
    for (int i = 0; i < MIN_ON - 1; i++) step(1, 2'b00, 0, S_PD, 2'b00, 1, "t3_pd_hold");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t3_dead3");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t3_dead4");
    step(1, 2'b00, 0, S_IDLE, 2'b00, 0, "t3_idle2");

    // 4: second pull-up joins without dead time
    for (int i = 0; i < 3; i++) step(1, 2'b01, 0, S_PU, 2'b01, 0, "t4_a");
    for (int i = 0; i < 3; i++) step(1, 2'b11, 0, S_PU, 2'b11, 0, "t4_ab");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t4_dead1");
    step(1, 2'b00, 0, S_DEAD, 2'b00, 0, "t4_dead2");
    step(1, 2'b00, 0, S_IDLE, 2'b00, 0, "t4_idle");

    // 5: enable drop in PD at on_cnt=2 ignores MIN_ON; no grants while disabled
    step(1, 2'b00, 1, S_PD, 2'b00, 1, "t5_pd1");
    step(1, 2'b00, 1, S_PD, 2'b00, 1, "t5_pd2");
    step(0, 2'b00, 1, S_DEAD, 2'b00, 0, "t5_dead1");
    step(0, 2'b11, 1, S_DEAD, 2'b00, 0, "t5_dead2");
    step(0, 2'b11, 1, S_IDLE, 2'b00, 0, "t5_idle");
    step(0, 2'b11, 1, S_IDLE, 2'b00, 0, "t5_blocked1");
    step(0, 2'b01, 0, S_IDLE, 2'b00, 0, "t5_blocked2");

    // 6: reset mid-PU goes straight to all-off
    step(1, 2'b10, 0, S_PU, 2'b10, 0, "t6_pu1");
    step(1, 2'b10, 0, S_PU, 2'b10, 0, "t6_pu2");
    rst_n = 1'b0;
    step(1, 2'b10, 0, S_IDLE, 2'b00, 0, "t6_reset");
    rst_n = 1'b1;

    // Random soak: break-before-make and the all-off gap between directions
    prev_dir = 0;
    off_run = 0;
    for (int i = 0; i < 10000; i++) begin
      en = ($urandom_range(0, 15) != 0);
      req_up = 2'($urandom_range(0, 3));
      req_dn = ($urandom_range(0, 2) == 0);
      @(posedge clk);
      #1;
      up_on = ~a_n | ~b_n;
      dn_on = c;
      n_cmp++;
      assert ((up_on & dn_on) === 1'b0) else begin
        n_fail++;
        $error("FAIL soak_overlap cyc=%0d a_n=%b b_n=%b c=%b exp=no_overlap", i, a_n, b_n, c);
      end
      if (up_on || dn_on) begin
        if ((up_on && prev_dir == 2) || (dn_on && prev_dir == 1)) begin
          n_cmp++;
          assert (off_run >= DEAD_CYC) else begin
            n_fail++;
            $error("FAIL soak_gap cyc=%0d off_run=%0d exp>=%0d", i, off_run, DEAD_CYC);
          end
        end
        prev_dir = up_on ? 1 : 2;
        off_run = 0;
      end else begin
        off_run++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
